// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// frame FSM states, line levels and the frame-length helper.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Total clock cycles occupied by one frame on the line.
    function automatic int frame_len(input int data_w, input int parity_en,
                                     input int clks_per_bit);
        return (2 + data_w + ((parity_en != 0) ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and strobes
// o_bit_end in the last cycle of each bit. Shared with the serial receiver.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // With CLKS_PER_BIT=1 LAST is 0, so the counter stays at 0 and every
    // enabled cycle is a bit end.
    assign o_bit_end = i_enable && (r_cnt == LAST);

    // Cycle counter within the current bit; wraps at each bit boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (r_cnt == LAST) r_cnt <= '0;
            else               r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter. A word accepted over valid/ready
// is sent as start bit, data bits, optional parity bit and stop bit, each
// held for CLKS_PER_BIT clocks. The line idles high.
module piso_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int MSB_FIRST    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_serial_out,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic [BW-1:0]     r_bit_idx;
    logic              r_serial;
    logic              r_busy;

    logic              w_bit_end;
    logic              w_stop_end;
    logic              w_ready;
    logic              w_hs;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shifted;

    // The timer runs only while a frame is on the line and is held at zero in
    // IDLE, so a new frame always starts on a fresh bit period.
    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (r_state == IDLE),
        .i_enable (r_state != IDLE),
        .o_bit_end(w_bit_end)
    );

    // Ready in IDLE and in the last stop-bit cycle, which allows back-to-back
    // frames with no idle gap.
    assign w_stop_end = (r_state == STOP) && w_bit_end;
    assign w_ready    = (r_state == IDLE) || w_stop_end;
    assign w_hs       = i_valid && w_ready;

    // The next data bit is always taken from the same end of the shift
    // register; the register shifts toward that end after each bit.
    assign w_next_bit = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];
    assign w_shifted  = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

    assign o_ready      = w_ready;
    assign o_done       = w_stop_end;
    assign o_busy       = r_busy;
    assign o_serial_out = r_serial;

    // Frame FSM with registered line level and busy flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_idx <= '0;
            r_serial  <= IDLE_LEVEL;
            r_busy    <= 1'b0;
        end else if (w_hs) begin
            // Capture happens only in IDLE or the final stop cycle.
            r_state   <= START;
            r_shift   <= i_data;
            r_parity  <= (^i_data) ^ ODD;
            r_bit_idx <= '0;
            r_serial  <= START_BIT;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_serial <= IDLE_LEVEL;
                    r_busy   <= 1'b0;
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_serial  <= w_next_bit;
                        r_shift   <= w_shifted;
                        r_bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                r_state  <= PARITY;
                                r_serial <= r_parity;
                            end else begin
                                r_state  <= STOP;
                                r_serial <= STOP_BIT;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                            r_serial  <= w_next_bit;
                            r_shift   <= w_shifted;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_state  <= STOP;
                        r_serial <= STOP_BIT;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state  <= IDLE;
                        r_serial <= IDLE_LEVEL;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_serial <= IDLE_LEVEL;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
